// File: rtl/softmax_phase_seq.sv
// Phase sequencer for a three-pass softmax: max scan, exp/sum (nes) and probability (pc) passes.
// Optional stall-cycle performance counter enabled by defining SOFTMAX_SEQ_PERF_CNT_EN.
module softmax_phase_seq #(
    parameter int DATA_SIZE = 1024,
    parameter int AW        = 10,
    parameter int MAX_LAT   = 2,
    parameter int NES_LAT   = 45,
    parameter int PROAB_LAT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          stall,
    output logic          busy,
    output logic          done,
    output logic [1:0]    phase,
    output logic          rd_ena,
    output logic [AW-1:0] rd_addr,
    output logic          max_ena,
    output logic          nes_ena,
    output logic          pc_ena,
    output logic          scale_update,
    output logic          sum_lock,
    output logic          wb_ena,
    output logic [AW-1:0] wb_addr,
    output logic [15:0]   stall_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MAX    = 3'd1;
    localparam logic [2:0] S_MAX_DR = 3'd2;
    localparam logic [2:0] S_NES    = 3'd3;
    localparam logic [2:0] S_NES_DR = 3'd4;
    localparam logic [2:0] S_PC     = 3'd5;
    localparam logic [2:0] S_PC_DR  = 3'd6;
    localparam logic [2:0] S_FIN    = 3'd7;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DATA_SIZE - 1);
    localparam logic [15:0]   MAX_LAT_C = 16'(MAX_LAT);
    localparam logic [15:0]   NES_LAT_C = 16'(NES_LAT);
    localparam logic [15:0]   PC_LAT_C  = 16'(PROAB_LAT);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   cnt_q, cnt_d;

    logic issue_st;
    logic drain_st;
    logic drain_exit;

    assign issue_st   = (state_q == S_MAX) || (state_q == S_NES) || (state_q == S_PC);
    assign drain_st   = (state_q == S_MAX_DR) || (state_q == S_NES_DR) || (state_q == S_PC_DR);
    // Last drain cycle: the transition (and any pulse tied to it) happens only when not frozen.
    assign drain_exit = drain_st && !stall && !abort && (cnt_q <= 16'd1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = S_IDLE;
            addr_d  = '0;
            cnt_d   = '0;
        end else if (!stall) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_MAX;
                        addr_d  = '0;
                    end
                end
                S_MAX, S_NES, S_PC: begin
                    if (addr_q == LAST_ADDR) begin
                        addr_d = '0;
                        case (state_q)
                            S_MAX:   begin state_d = S_MAX_DR; cnt_d = MAX_LAT_C; end
                            S_NES:   begin state_d = S_NES_DR; cnt_d = NES_LAT_C; end
                            default: begin state_d = S_PC_DR;  cnt_d = PC_LAT_C;  end
                        endcase
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                S_MAX_DR, S_NES_DR, S_PC_DR: begin
                    if (cnt_q <= 16'd1) begin
                        cnt_d = '0;
                        case (state_q)
                            S_MAX_DR: state_d = S_NES;
                            S_NES_DR: state_d = S_PC;
                            default:  state_d = S_FIN;
                        endcase
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign rd_ena       = issue_st && !stall;
    assign rd_addr      = addr_q;
    assign max_ena      = (state_q == S_MAX) || (state_q == S_MAX_DR);
    assign nes_ena      = (state_q == S_NES) || (state_q == S_NES_DR);
    assign pc_ena       = (state_q == S_PC)  || (state_q == S_PC_DR);
    assign phase        = max_ena ? 2'd1 : nes_ena ? 2'd2 : pc_ena ? 2'd3 : 2'd0;
    assign scale_update = drain_exit && (state_q == S_MAX_DR);
    assign sum_lock     = drain_exit && (state_q == S_NES_DR);
    assign done         = (state_q == S_FIN) && !stall && !abort;

    // Write-back delay line mirrors the pc datapath latency; it freezes with the pipe.
    logic          wb_vld_q [PROAB_LAT];
    logic [AW-1:0] wb_adr_q [PROAB_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst || abort) begin
            for (int i = 0; i < PROAB_LAT; i++) begin
                wb_vld_q[i] <= 1'b0;
                wb_adr_q[i] <= '0;
            end
        end else if (!stall) begin
            wb_vld_q[0] <= (state_q == S_PC);
            wb_adr_q[0] <= addr_q;
            for (int i = 1; i < PROAB_LAT; i++) begin
                wb_vld_q[i] <= wb_vld_q[i-1];
                wb_adr_q[i] <= wb_adr_q[i-1];
            end
        end
    end

    // Gating by stall keeps one write per element while the output stage is frozen.
    assign wb_ena  = wb_vld_q[PROAB_LAT-1] && !stall;
    assign wb_addr = wb_adr_q[PROAB_LAT-1];

`ifdef SOFTMAX_SEQ_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if ((state_q == S_IDLE) && start && !abort && !stall) begin
            stall_cnt_q <= '0;
        end else if (busy && stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_softmax_phase_seq.sv
// Directed bench for softmax_phase_seq with DATA_SIZE=8, MAX_LAT=2, NES_LAT=3, PROAB_LAT=3.
module tb_softmax_phase_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       stall = 1'b0;
    logic       busy, done, rd_ena, max_ena, nes_ena, pc_ena, scale_update, sum_lock, wb_ena;
    logic [1:0] phase;
    logic [3:0] rd_addr, wb_addr;
    logic [15:0] stall_cnt;

    softmax_phase_seq #(
        .DATA_SIZE(8), .AW(4), .MAX_LAT(2), .NES_LAT(3), .PROAB_LAT(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
        .busy(busy), .done(done), .phase(phase), .rd_ena(rd_ena), .rd_addr(rd_addr),
        .max_ena(max_ena), .nes_ena(nes_ena), .pc_ena(pc_ena),
        .scale_update(scale_update), .sum_lock(sum_lock),
        .wb_ena(wb_ena), .wb_addr(wb_addr), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc, n_done, done_at, n_su, su_at, n_sl, sl_at, n_wb, wb_first, wb_last, wb_bad, ph_bad;
    int n_mi, n_md, n_ni, n_nd, n_pi, n_pd, n_fin, hold_bad;
    logic [3:0] wb_exp;

    task automatic clr();
        cyc = 0; n_done = 0; done_at = -1; n_su = 0; su_at = -1; n_sl = 0; sl_at = -1;
        n_wb = 0; wb_first = -1; wb_last = -1; wb_bad = 0; ph_bad = 0; hold_bad = 0;
        n_mi = 0; n_md = 0; n_ni = 0; n_nd = 0; n_pi = 0; n_pd = 0; n_fin = 0;
        wb_exp = 4'd0;
    endtask

    // One cycle: drive inputs after the falling edge, then record what the DUT shows.
    task automatic tick(input logic st, input logic ab, input logic sl);
        @(negedge clk);
        start = st; abort = ab; stall = sl;
        #1;
        if (max_ena) begin if (rd_ena) n_mi++; else n_md++; end
        if (nes_ena) begin if (rd_ena) n_ni++; else n_nd++; end
        if (pc_ena)  begin if (rd_ena) n_pi++; else n_pd++; end
        if (busy && !max_ena && !nes_ena && !pc_ena) n_fin++;
        if (phase !== (max_ena ? 2'd1 : nes_ena ? 2'd2 : pc_ena ? 2'd3 : 2'd0)) ph_bad++;
        if (done) begin n_done++; done_at = cyc; end
        if (scale_update) begin n_su++; su_at = cyc; end
        if (sum_lock) begin n_sl++; sl_at = cyc; end
        if (wb_ena) begin
            if (wb_addr !== wb_exp) wb_bad++;
            wb_exp = wb_exp + 4'd1;
            n_wb++;
            if (wb_first < 0) wb_first = cyc;
            wb_last = cyc;
        end
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_chk++;
        if ({busy, done, phase, rd_ena, rd_addr, max_ena, nes_ena, pc_ena, scale_update,
             sum_lock, wb_ena, wb_addr, stall_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got busy=%b phase=%0d rd_addr=%0d wb_addr=%0d stall_cnt=%0d, want all 0",
                               busy, phase, rd_addr, wb_addr, stall_cnt);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        n_chk++;
        if (busy !== 1'b0 || rd_addr !== 4'd0) begin
            n_fail++; $display("FAIL idle_after_reset: got busy=%b rd_addr=%0d, want 0 0", busy, rd_addr);
        end
    endtask

    task automatic test_full_run();
        clr();
        tick(1'b1, 1'b0, 1'b0);
        repeat (39) tick(1'b0, 1'b0, 1'b0);
        n_chk++; if (n_mi !== 8) begin n_fail++; $display("FAIL max_issue_cycles: got %0d want 8", n_mi); end
        n_chk++; if (n_md !== 2) begin n_fail++; $display("FAIL max_drain_cycles: got %0d want 2", n_md); end
        n_chk++; if (n_ni !== 8) begin n_fail++; $display("FAIL nes_issue_cycles: got %0d want 8", n_ni); end
        n_chk++; if (n_nd !== 3) begin n_fail++; $display("FAIL nes_drain_cycles: got %0d want 3", n_nd); end
        n_chk++; if (n_pi !== 8) begin n_fail++; $display("FAIL pc_issue_cycles: got %0d want 8", n_pi); end
        n_chk++; if (n_pd !== 3) begin n_fail++; $display("FAIL pc_drain_cycles: got %0d want 3", n_pd); end
        n_chk++; if (n_fin !== 1) begin n_fail++; $display("FAIL fin_cycles: got %0d want 1", n_fin); end
        n_chk++; if (n_done !== 1 || done_at !== 33) begin
            n_fail++; $display("FAIL done_timing: got count=%0d at=%0d want 1 at 33", n_done, done_at); end
        n_chk++; if (n_su !== 1 || su_at !== 10) begin
            n_fail++; $display("FAIL scale_update: got count=%0d at=%0d want 1 at 10", n_su, su_at); end
        n_chk++; if (n_sl !== 1 || sl_at !== 21) begin
            n_fail++; $display("FAIL sum_lock: got count=%0d at=%0d want 1 at 21", n_sl, sl_at); end
        n_chk++; if (n_wb !== 8 || wb_bad !== 0) begin
            n_fail++; $display("FAIL wb_sequence: got count=%0d bad_addr=%0d want 8 0", n_wb, wb_bad); end
        n_chk++; if (wb_first !== 25 || wb_last !== 32) begin
            n_fail++; $display("FAIL wb_window: got first=%0d last=%0d want 25 32", wb_first, wb_last); end
        n_chk++; if (ph_bad !== 0) begin n_fail++; $display("FAIL phase_grouping: got %0d bad cycles want 0", ph_bad); end
        n_chk++; if (busy !== 1'b0 || stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL idle_after_run: got busy=%b stall_cnt=%0d want 0 0", busy, stall_cnt); end
    endtask

    task automatic test_stall();
        logic [15:0] exp_sc;
`ifdef SOFTMAX_SEQ_PERF_CNT_EN
        exp_sc = 16'd4;
`else
        exp_sc = 16'd0;
`endif
        clr();
        tick(1'b1, 1'b0, 1'b0);
        repeat (15) tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (rd_addr !== 4'd5 || rd_ena !== 1'b0 || !nes_ena) hold_bad++;
        end
        tick(1'b0, 1'b0, 1'b0);
        if (rd_addr !== 4'd5 || rd_ena !== 1'b1) hold_bad++;
        repeat (25) tick(1'b0, 1'b0, 1'b0);
        n_chk++; if (hold_bad !== 0) begin n_fail++; $display("FAIL stall_hold_addr: got %0d bad cycles want 0", hold_bad); end
        n_chk++; if (n_done !== 1 || done_at !== 37) begin
            n_fail++; $display("FAIL stall_done_timing: got count=%0d at=%0d want 1 at 37", n_done, done_at); end
        n_chk++; if (stall_cnt !== exp_sc) begin
            n_fail++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, exp_sc); end
        n_chk++; if (n_wb !== 8 || wb_bad !== 0 || n_su !== 1 || n_sl !== 1) begin
            n_fail++; $display("FAIL stall_run_outputs: got wb=%0d bad=%0d su=%0d sl=%0d want 8 0 1 1", n_wb, wb_bad, n_su, n_sl); end
    endtask

    task automatic test_abort();
        int wb_before;
        clr();
        tick(1'b1, 1'b0, 1'b0);
        repeat (24) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        n_chk++; if (!pc_ena || rd_addr !== 4'd3) begin
            n_fail++; $display("FAIL abort_point: got pc_ena=%b rd_addr=%0d want 1 3", pc_ena, rd_addr); end
        wb_before = n_wb;
        tick(1'b0, 1'b0, 1'b0);
        n_chk++; if (busy !== 1'b0 || phase !== 2'd0 || rd_addr !== 4'd0) begin
            n_fail++; $display("FAIL abort_to_idle: got busy=%b phase=%0d rd_addr=%0d want 0 0 0", busy, phase, rd_addr); end
        repeat (15) tick(1'b0, 1'b0, 1'b0);
        n_chk++; if (n_done !== 0 || n_wb !== wb_before) begin
            n_fail++; $display("FAIL abort_quiet: got done=%0d wb_after=%0d want 0 0", n_done, n_wb - wb_before); end
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_beats_start: got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        clr();
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 60; i++) tick((i == 5 || i == 20 || i == 33), 1'b0, 1'b0);
        n_chk++; if (n_done !== 1 || done_at !== 33) begin
            n_fail++; $display("FAIL restart_ignored: got done count=%0d at=%0d want 1 at 33", n_done, done_at); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_rst_mid();
        clr();
        tick(1'b1, 1'b0, 1'b0);
        repeat (20) tick(1'b0, 1'b0, 1'b0);
        n_chk++; if (!nes_ena || rd_ena) begin
            n_fail++; $display("FAIL rst_point: got nes_ena=%b rd_ena=%b want 1 0", nes_ena, rd_ena); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_chk++;
        if ({busy, done, phase, rd_ena, rd_addr, max_ena, nes_ena, pc_ena, scale_update,
             sum_lock, wb_ena, wb_addr, stall_cnt} !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got busy=%b phase=%0d rd_addr=%0d wb_addr=%0d, want all 0",
                               busy, phase, rd_addr, wb_addr);
        end
        n_chk++; if (n_done !== 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d want 0", n_done); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clr();
        tick(1'b1, 1'b0, 1'b0);
        repeat (39) tick(1'b0, 1'b0, 1'b0);
        n_chk++; if (n_done !== 1 || done_at !== 33 || n_wb !== 8 || wb_bad !== 0) begin
            n_fail++; $display("FAIL rst_rerun: got done=%0d at=%0d wb=%0d bad=%0d want 1 33 8 0", n_done, done_at, n_wb, wb_bad); end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_stall();
        test_abort();
        test_back_to_back();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/softmax_phase_seq.md
SOFTMAX_PHASE_SEQ -- requirements
Module: softmax_phase_seq

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 1024, meaning elements per softmax pass.
REQ-002 SHALL have parameter AW, default 10, meaning address width; DATA_SIZE <= 2^AW.
REQ-003 SHALL have parameters MAX_LAT (default 2), NES_LAT (default 45) and PROAB_LAT (default 16), meaning datapath drain latency in cycles per phase; each is >= 1.
REQ-004 SHALL have port clk, input, 1, clock; reset rst, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, request a full softmax run.
REQ-006 SHALL have port abort, input, 1, synchronous cancel of the current run.
REQ-007 SHALL have port stall, input, 1, freezes issue, drain counters and the wb delay line.
REQ-008 SHALL have outputs busy (1), done (1, pulse) and phase (2: 0=idle, 1=max, 2=nes, 3=proab).
REQ-009 SHALL have outputs rd_ena (1) and rd_addr (AW), the input-memory read strobe and address.
REQ-010 SHALL have outputs max_ena, nes_ena and pc_ena (1 each), the phase datapath enables.
REQ-011 SHALL have outputs scale_update (1, pulse) and sum_lock (1, pulse).
REQ-012 SHALL have outputs wb_ena (1) and wb_addr (AW), the output-memory write strobe and address.
REQ-013 SHALL have output stall_cnt (16), the stall-cycle count.

Function
REQ-014 SHALL implement FSM states IDLE, MAX, MAX_DR, NES, NES_DR, PC, PC_DR, FIN.
REQ-015 IDLE SHALL move to MAX on start=1 and clear rd_addr to 0; start outside IDLE SHALL be ignored.
REQ-016 In MAX, NES and PC: rd_ena = !stall; rd_addr SHALL increment after each cycle with rd_ena=1.
REQ-017 After the issue with rd_addr = DATA_SIZE-1, the FSM SHALL enter the matching _DR state and rd_addr SHALL wrap to 0.
REQ-018 Each _DR state SHALL load a down-counter with its *_LAT, decrement on !stall cycles and exit when the count reaches 0.
REQ-019 The exit transitions SHALL be MAX_DR->NES, NES_DR->PC and PC_DR->FIN.
REQ-020 scale_update SHALL pulse for exactly one cycle on the MAX_DR->NES transition.
REQ-021 sum_lock SHALL pulse for exactly one cycle on the NES_DR->PC transition.
REQ-022 FIN SHALL assert done for exactly one cycle and then return to IDLE.
REQ-023 max_ena, nes_ena and pc_ena SHALL be high during their issue state and its _DR state; phase SHALL track the same grouping.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 wb_ena/wb_addr SHALL equal the PC-phase rd_ena/rd_addr delayed by PROAB_LAT shift stages that advance only when stall=0.
REQ-026 Exactly DATA_SIZE wb_ena pulses SHALL occur per run, the last no later than the cycle entering FIN.
REQ-027 abort=1 in any state SHALL force IDLE on the next edge, clear counters and the wb delay line, and produce no done.
REQ-028 If abort and start are both high in IDLE, abort SHALL win.
REQ-029 stall SHALL hold the FSM, counters and addresses unchanged; pulse outputs SHALL NOT assert during a stalled cycle and SHALL fire on the first unstalled cycle.

Reset
REQ-030 rst SHALL force IDLE and set every output to 0, including rd_addr, wb_addr and stall_cnt, and clear all counters and delay stages.
REQ-031 rst asserted mid-run SHALL abandon the run with no done pulse.

Configuration
REQ-032 With macro SOFTMAX_SEQ_PERF_CNT_EN defined, stall_cnt SHALL clear on the accepted start and count cycles with busy=1 and stall=1, saturating at 16'hFFFF.
REQ-033 Without SOFTMAX_SEQ_PERF_CNT_EN, stall_cnt SHALL be constant 0 and no counter logic SHALL be present.

Verification (DATA_SIZE=8, MAX_LAT=2, NES_LAT=3, PROAB_LAT=3)
REQ-034 SHALL check: start pulse with no stall -> MAX 8, MAX_DR 2, NES 8, NES_DR 3, PC 8, PC_DR 3, FIN 1 cycles; done 33 cycles after start sampled.
REQ-035 SHALL check: stall held 4 cycles in NES at rd_addr=5 -> rd_addr holds 5, done 4 cycles late, stall_cnt=4 with the macro and 0 without.
REQ-036 SHALL check: abort in PC at rd_addr=3 -> IDLE next cycle, no done, wb_ena stays 0 after that.
REQ-037 SHALL check: start re-asserted while busy -> ignored, exactly one done.
REQ-038 SHALL check: rst asserted in NES_DR -> all outputs 0 immediately; a new start after release runs the full 33-cycle sequence.
REQ-039 SHALL check: wb_addr sequence 0..7 with wb_ena, and scale_update and sum_lock each seen exactly once per run.
